pipe_adder: RTL

Parametrised, carry-pipelined adder. It generalises our single-bit combinational half adder to a WIDTH-bit add with carry-in, carry-out and a valid/ready handshake. The carry chain is split into CHUNK-bit slices with one register stage per slice, so wide adds close timing at full clock rate. It sits in the datapath between operand-producing stages and any downstream consumer that can apply backpressure.

---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/pipe_adder_slice.sv | 18 +
 rtl/pipe_adder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the carry-pipelined adder (pipe_adder).
// The stage count is derived once here so the top and any wrappers agree on it.
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // Per-stage control payload: occupancy and the carry handed to the next slice.
  // Slice sums are width-dependent, so they live in the stage's own registers.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational CHUNK-bit adder with carry-in and carry-out; one per pipeline stage.
module pipe_adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// WIDTH-bit adder with the carry chain split into CHUNK-bit registered stages and a
// valid/ready handshake on both sides. Optional signed overflow via PIPE_ADDER_OVF_EN.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      localparam int LO = gi * CHUNK;
      localparam int HI = LO + CHUNK;

      stage_ctl_t       ctl_reg;
      logic [HI-1:0]    sum_reg;
      logic [HI-1:0]    sum_next;
      logic [CHUNK-1:0] op_a;
      logic [CHUNK-1:0] op_b;
      logic [CHUNK-1:0] slice_sum;
      logic             carry_in;
      logic             slice_cout;
      logic             valid_in;
      logic             load;

      if (gi == 0) begin : gen_src
        assign op_a     = a[CHUNK-1:0];
        assign op_b     = b[CHUNK-1:0];
        assign carry_in = cin;
        assign valid_in = in_valid;
        assign sum_next = slice_sum;
      end else begin : gen_src
        assign op_a     = gen_stage[gi-1].gen_skew.a_reg[HI-1:LO];
        assign op_b     = gen_stage[gi-1].gen_skew.b_reg[HI-1:LO];
        assign carry_in = gen_stage[gi-1].ctl_reg.carry;
        assign valid_in = gen_stage[gi-1].ctl_reg.valid;
        assign sum_next = {slice_sum, gen_stage[gi-1].sum_reg};
      end

      pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_in),
        .s    (slice_sum),
        .cout (slice_cout)
      );

      // A stage stalls only when it and every stage downstream hold a beat and the
      // consumer is not taking one; this is the unrolled form of the advance chain.
      assign valid_vec[gi] = ctl_reg.valid;
      assign adv[gi]       = ~(&valid_vec[STAGES-1:gi]) | out_ready;
      assign load          = adv[gi] & valid_in;

      // Data only moves with a real beat, so an empty pipeline keeps its last outputs.
      always_ff @(posedge clk) begin
        if (rst) begin
          ctl_reg <= '0;
          sum_reg <= '0;
        end else begin
          if (adv[gi]) begin
            ctl_reg.valid <= valid_in;
          end
          if (load) begin
            ctl_reg.carry <= slice_cout;
            sum_reg       <= sum_next;
          end
        end
      end

      // Upper operand slices ride along until their own stage consumes them.
      if (gi < STAGES - 1) begin : gen_skew
        logic [WIDTH-1:HI] a_reg;
        logic [WIDTH-1:HI] b_reg;
        logic [WIDTH-1:HI] a_next;
        logic [WIDTH-1:HI] b_next;

        if (gi == 0) begin : gen_tap
          assign a_next = a[WIDTH-1:HI];
          assign b_next = b[WIDTH-1:HI];
        end else begin : gen_tap
          assign a_next = gen_stage[gi-1].gen_skew.a_reg[WIDTH-1:HI];
          assign b_next = gen_stage[gi-1].gen_skew.b_reg[WIDTH-1:HI];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (load) begin
            a_reg <= a_next;
            b_reg <= b_next;
          end
        end
      end

`ifdef PIPE_ADDER_OVF_EN
      // The last slice sees the skewed sign bits of both operands and the sum's sign.
      if (gi == STAGES - 1) begin : gen_ovf
        logic ovf_reg;

        always_ff @(posedge clk) begin
          if (rst) begin
            ovf_reg <= 1'b0;
          end else if (load) begin
            ovf_reg <= (op_a[CHUNK-1] == op_b[CHUNK-1]) &&
                       (slice_sum[CHUNK-1] != op_a[CHUNK-1]);
          end
        end
      end
`endif
    end
  endgenerate

  assign in_ready  = adv[0] & ~rst;
  assign out_valid = valid_vec[STAGES-1];
  assign s         = gen_stage[STAGES-1].sum_reg;
  assign cout      = gen_stage[STAGES-1].ctl_reg.carry;

`ifdef PIPE_ADDER_OVF_EN
  assign ovf = gen_stage[STAGES-1].gen_ovf.ovf_reg;
`endif

endmodule
